// File: rtl/seq_alu.sv
// seq_alu: registered, valid/ready handshaked ALU with shifts and optional iterative mul/divu/remu.
// Define SEQ_ALU_MULDIV_EN to build the iterative multiply/divide engine; otherwise ops 11-13 return 0.
module seq_alu #(
   parameter  int WIDTH   = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             busy
);

   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_NOR  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12;
   localparam logic [3:0] OP_REMU = 4'd13;

   function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [SHAMT_W-1:0]      sh;
      sa = a;
      sb = b;
      sh = b[SHAMT_W-1:0];
      case (op)
         OP_AND:  alu_single = a & b;
         OP_OR:   alu_single = a | b;
         OP_ADD:  alu_single = a + b;
         OP_SUB:  alu_single = a - b;
         OP_SLT:  alu_single = (sa < sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
         OP_NOR:  alu_single = ~(a | b);
         OP_XOR:  alu_single = a ^ b;
         OP_SLL:  alu_single = a << sh;
         OP_SRL:  alu_single = a >> sh;
         OP_SRA:  alu_single = sa >>> sh;
         default: alu_single = '0;
      endcase
   endfunction

   logic             accept;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;

   assign accept = in_valid && in_ready;

`ifdef SEQ_ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [SHAMT_W:0]   cnt;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   acc;   // product (mul) or partial remainder (div)
   logic [WIDTH-1:0]   sreg;  // multiplicand (mul) or dividend/quotient shifter (div)
   logic [WIDTH-1:0]   breg;  // multiplier (mul) or divisor (div)
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic               is_iter_op;
   logic               start;

   assign is_iter_op = (control == OP_MUL) || (control == OP_DIVU) || (control == OP_REMU);
   assign start      = accept && is_iter_op;
   assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
   assign busy       = (state != IDLE);
   assign rem_sh     = {acc, sreg[WIDTH-1]};
   assign diff       = rem_sh - {1'b0, breg};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ITER;
         ITER:    if (cnt == (SHAMT_W+1)'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                cnt <= '0;
      else if (start)         cnt <= (SHAMT_W+1)'(WIDTH);
      else if (state == ITER) cnt <= cnt - (SHAMT_W+1)'(1);
   end

   // Iteration datapath: one multiplier bit or one restoring-division quotient bit per cycle.
   always_ff @(posedge clk) begin
      if (start) begin
         op_q <= control;
         acc  <= '0;
         sreg <= in1;
         breg <= in2;
      end else if (state == ITER) begin
         if (op_q == OP_MUL) begin
            if (breg[0]) acc <= acc + sreg;
            sreg <= sreg << 1;
            breg <= breg >> 1;
         end else if (!diff[WIDTH]) begin
            acc  <= diff[WIDTH-1:0];
            sreg <= {sreg[WIDTH-2:0], 1'b1};
         end else begin
            acc  <= rem_sh[WIDTH-1:0];
            sreg <= {sreg[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign wr_en   = (accept && !is_iter_op) || (state == DONE);
   assign wr_data = (state == DONE) ? ((op_q == OP_DIVU) ? sreg : acc)
                                    : alu_single(control, in1, in2);
`else
   assign in_ready = !out_valid || out_ready;
   assign busy     = 1'b0;
   assign wr_en    = accept;
   assign wr_data  = alu_single(control, in1, in2);
`endif

   // Result register: a new write wins over a simultaneous drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else if (wr_en) begin
         out       <= wr_data;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign zero = (out == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu; expectations for ops 11-13 follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
   localparam int WIDTH = 32;

`ifdef SEQ_ALU_MULDIV_EN
   localparam bit MULDIV = 1'b1;
`else
   localparam bit MULDIV = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [3:0]       control;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .control(control), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .zero(zero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in1 = '0; in2 = '0; control = 4'd0;
      step(); step();
      n_cmp++; if (out !== '0)        begin n_bad++; $display("FAIL reset_out: got %h want 0", out); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (zero !== 1'b1)      begin n_bad++; $display("FAIL reset_zero: got %b want 1", zero); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_single_cycle();
      logic [3:0]  ops  [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd14};
      logic [31:0] exps [9] = '{32'h0, 32'hF, 32'hF, 32'hFFFF_FFFB, 32'h1, 32'hFFFF_FFF0, 32'hF, 32'h0, 32'h0};
      in1 = 32'd5; in2 = 32'd10; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         control = ops[i];
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready op%0d: got %b want 1", ops[i], in_ready); end
         step();
         n_cmp++;
         if ({out_valid, out} !== {1'b1, exps[i]}) begin
            n_bad++; $display("FAIL single_op%0d: got vld=%b out=%h want vld=1 out=%h", ops[i], out_valid, out, exps[i]);
         end
         n_cmp++; if (zero !== (exps[i] == 32'h0)) begin n_bad++; $display("FAIL single_zero op%0d: got %b want %b", ops[i], zero, exps[i] == 32'h0); end
      end
      in_valid = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got vld=%b want 0", out_valid); end
   endtask

   task automatic test_shifts();
      logic [3:0]  ops [6] = '{4'd10, 4'd9, 4'd8, 4'd5, 4'd5, 4'd3};
      logic [31:0] a   [6] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'd10, 32'hFFFF_FFFF};
      logic [31:0] b   [6] = '{32'h24, 32'h24, 32'd31, 32'h1, 32'd5, 32'h2};
      logic [31:0] exps[6] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h1, 32'h0, 32'h1};
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         control = ops[i]; in1 = a[i]; in2 = b[i];
         step();
         n_cmp++;
         if ({out_valid, out} !== {1'b1, exps[i]}) begin
            n_bad++; $display("FAIL shift_vec%0d op%0d: got vld=%b out=%h want vld=1 out=%h", i, ops[i], out_valid, out, exps[i]);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_muldiv();
      logic [3:0]  ops [6] = '{4'd11, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13};
      logic [31:0] a   [6] = '{32'h0001_0001, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234, 32'h1234};
      logic [31:0] b   [6] = '{32'h0001_0001, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'h0, 32'h0};
      logic [31:0] vals[6] = '{32'h0002_0001, 32'h1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234};
      logic [31:0] exp_val;
      int          exp_edges;
      int          edges;
      logic        busy_ok;
      exp_edges = MULDIV ? WIDTH + 1 : 0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_val = MULDIV ? vals[i] : 32'h0;
         control = ops[i]; in1 = a[i]; in2 = b[i]; in_valid = 1'b1;
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL muldiv_in_ready vec%0d: got %b want 1", i, in_ready); end
         step();
         in_valid = 1'b0; in1 = 32'hDEAD_BEEF; in2 = 32'h3; control = 4'd3;
         edges = 0; busy_ok = 1'b1;
         while (out_valid !== 1'b1 && edges < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
            step();
            edges++;
         end
         n_cmp++; if (edges != exp_edges) begin n_bad++; $display("FAIL muldiv_latency vec%0d: got %0d edges want %0d", i, edges, exp_edges); end
         n_cmp++; if (out !== exp_val)   begin n_bad++; $display("FAIL muldiv_result vec%0d op%0d: got %h want %h", i, ops[i], out, exp_val); end
         n_cmp++; if (busy_ok !== 1'b1)  begin n_bad++; $display("FAIL muldiv_busy_stall vec%0d: busy/in_ready wrong during iteration", i); end
         n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL muldiv_busy_end vec%0d: got %b want 0", i, busy); end
      end
      step();
   endtask

   task automatic test_backpressure();
      logic stable_ok;
      in1 = 32'd20; in2 = 32'd22; control = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
      step();
      control = 4'd2;
      stable_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
         step();
      end
      n_cmp++; if (stable_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold: out=%h vld=%b rdy=%b want out=2a held, vld=1, rdy=0", out, out_valid, in_ready); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      step();
      n_cmp++;
      if ({out_valid, out} !== {1'b1, 32'd22}) begin
         n_bad++; $display("FAIL bp_new_wins: got vld=%b out=%h want vld=1 out=16", out_valid, out);
      end
      in_valid = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got vld=%b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_iter();
      logic quiet_ok;
      out_ready = 1'b1;
      control = 4'd11; in1 = 32'h0001_0001; in2 = 32'h0001_0001; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out !== '0)         begin n_bad++; $display("FAIL rstmid_out: got %h want 0", out); end
      control = 4'd3; in1 = 32'd3; in2 = 32'd4; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, out} !== {1'b1, 32'd7}) begin
         n_bad++; $display("FAIL rstmid_add: got vld=%b out=%h want vld=1 out=7", out_valid, out);
      end
      quiet_ok = 1'b1;
      repeat (40) begin
         step();
         if (out_valid !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
      end
      n_cmp++; if (quiet_ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_no_stale: vld=%b busy=%b out=%h after abort", out_valid, busy, out); end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_shifts();
      test_muldiv();
      test_backpressure();
      test_reset_mid_iter();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
